// File: rtl/key_event_ctl.sv
// key_event_ctl: debounced keys with short/long/repeat events, 1-deep event register with overflow, mode stepper.
//   sys_clk/sys_rst        : clock, async active-high reset
//   key_n                  : raw active-low keys (asynchronous)
//   key_level              : debounced levels, 1 = pressed
//   evt_valid/evt_ready    : event register handshake
//   evt_key/evt_type       : key index, type 01 short 10 long 11 repeat
//   evt_overflow/ovf_clr   : sticky lost-event flag and its clear
//   working_mode           : mode, stepped by key-0 short, zeroed by key-0 long
module key_event_ctl #(
  parameter int NUM_KEYS = 7,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int LONG_CYC = 25000000,
  parameter int REPEAT_CYC = 5000000,
  parameter int NUM_MODES = 3,
  localparam int KEY_W = NUM_KEYS > 2 ? $clog2(NUM_KEYS) : 1,
  localparam int MODE_W = NUM_MODES > 2 ? $clog2(NUM_MODES) : 1
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [KEY_W-1:0]    evt_key,
  output logic [1:0]          evt_type,
  output logic                evt_overflow,
  input  logic                ovf_clr,
  output logic [MODE_W-1:0]   working_mode
);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int HW = $clog2(LONG_CYC + 1);
  localparam int RW = $clog2(REPEAT_CYC + 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] LONG_M1 = HW'(LONG_CYC - 1);
  localparam logic [HW-1:0] LONG_MAX = HW'(LONG_CYC);
  localparam logic [RW-1:0] RPT_M1 = RW'(REPEAT_CYC - 1);
  localparam logic [MODE_W-1:0] MODE_MAX = MODE_W'(NUM_MODES - 1);
  logic [NUM_KEYS-1:0] lp, sp, rp;
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    logic s1, s2, lvl, diff, flip;
    logic [DW-1:0] deb;
    logic [HW-1:0] hold;
    logic [RW-1:0] rpt;
    assign diff = ~s2 ^ lvl;
    assign flip = diff && deb == DEB_MAX;
    // Pulses are taken while lvl is still 1, so a release on the very cycle
    // the hold count reaches LONG-1 yields the long pulse, never a short one.
    assign lp[k] = lvl && hold == LONG_M1;
    assign sp[k] = lvl && flip && hold < LONG_M1;
    assign rp[k] = lvl && hold == LONG_MAX && rpt == RPT_M1;
    assign key_level[k] = lvl;
    always_ff @(posedge sys_clk or posedge sys_rst)
      if (sys_rst) begin
        s1 <= 1'b1;
        s2 <= 1'b1;
        lvl <= 1'b0;
        deb <= '0;
        hold <= '0;
        rpt <= '0;
      end else begin
        s1 <= key_n[k];
        s2 <= s1;
        deb <= (diff && deb != DEB_MAX) ? deb + 1'b1 : '0;
        lvl <= lvl ^ flip;
        hold <= !lvl ? '0 : hold == LONG_MAX ? hold : hold + 1'b1;
        rpt <= (lvl && hold == LONG_MAX && rpt != RPT_M1) ? rpt + 1'b1 : '0;
      end
  end
  logic any, multi, load, loss;
  logic [KEY_W-1:0] pk;
  logic [1:0] pt;
  // Scan high to low so the lowest-index pulsing key wins.
  always_comb begin
    any = 1'b0;
    multi = 1'b0;
    pk = '0;
    pt = 2'b00;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (lp[i] || sp[i] || rp[i]) begin
        multi = multi | any;
        any = 1'b1;
        pk = KEY_W'(i);
        pt = lp[i] ? 2'b10 : rp[i] ? 2'b11 : 2'b01;
      end
  end
  assign load = !evt_valid || evt_ready;
  assign loss = any && (!load || multi);
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      evt_valid <= 1'b0;
      evt_key <= '0;
      evt_type <= 2'b00;
      evt_overflow <= 1'b0;
      working_mode <= '0;
    end else begin
      if (load) begin
        evt_valid <= any;
        evt_key <= pk;
        evt_type <= pt;
      end
      evt_overflow <= loss || (evt_overflow && !ovf_clr);
      working_mode <= lp[0] ? '0 : !sp[0] ? working_mode : working_mode == MODE_MAX ? '0 : working_mode + 1'b1;
    end
endmodule

// File: tb/tb_key_event_ctl.sv
// tb_key_event_ctl: directed stimulus with an event scoreboard for key_event_ctl.
module tb_key_event_ctl;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] key_n = 4'hF;
  logic [3:0] key_level;
  logic evt_valid, evt_ready = 1'b1, evt_overflow, ovf_clr = 1'b0;
  logic [1:0] evt_key, evt_type, working_mode;
  int checks = 0, fails = 0, cyc = 0, last_cyc = 0;
  logic [3:0] lvl_seen = '0;
  typedef struct {logic [1:0] key; logic [1:0] typ; int gap;} exp_t;
  exp_t q[$];
  key_event_ctl #(.NUM_KEYS(4), .DEBOUNCE_CYC(4), .LONG_CYC(20), .REPEAT_CYC(8), .NUM_MODES(3)) dut (
    .sys_clk(clk), .sys_rst(rst), .key_n(key_n), .key_level(key_level),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_key(evt_key), .evt_type(evt_type),
    .evt_overflow(evt_overflow), .ovf_clr(ovf_clr), .working_mode(working_mode));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) lvl_seen = lvl_seen | key_level;
  always @(negedge clk)
    if (!rst && evt_valid && evt_ready) begin
      checks++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event act key=%0d type=%b exp none", evt_key, evt_type);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (evt_key !== e.key || evt_type !== e.typ) begin
          fails++;
          $display("FAIL event act key=%0d type=%b exp key=%0d type=%b", evt_key, evt_type, e.key, e.typ);
        end
        if (e.gap != 0) begin
          checks++;
          if (cyc - last_cyc != e.gap) begin
            fails++;
            $display("FAIL event_gap act=%0d exp=%0d", cyc - last_cyc, e.gap);
          end
        end
      end
      last_cyc = cyc;
    end
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask
  task automatic press(int k, int n);
    key_n[k] = 1'b0;
    tick(n);
    key_n[k] = 1'b1;
  endtask
  task automatic expect_evt(logic [1:0] k, logic [1:0] t, int gap);
    exp_t e;
    e.key = k;
    e.typ = t;
    e.gap = gap;
    q.push_back(e);
  endtask
  initial begin
    tick(3);
    chk("rst_level", key_level, 0);
    chk("rst_valid", evt_valid, 0);
    chk("rst_mode", working_mode, 0);
    rst = 1'b0;
    tick(3);
    lvl_seen = '0;
    press(1, 3);
    tick(12);
    chk("glitch_level", lvl_seen, 0);
    lvl_seen = '0;
    expect_evt(2, 2'b01, 0);
    press(2, 10);
    tick(12);
    chk("short_level_rose", lvl_seen, 4'b0100);
    chk("short_level_fell", key_level, 0);
    expect_evt(3, 2'b10, 0);
    for (int i = 0; i < 3; i++) expect_evt(3, 2'b11, 8);
    press(3, 45);
    tick(12);
    chk("long_level_fell", key_level, 0);
    for (int i = 0; i < 4; i++) begin
      expect_evt(0, 2'b01, 0);
      press(0, 10);
      tick(12);
      chk("mode_step", working_mode, (i + 1) % 3);
    end
    expect_evt(0, 2'b10, 0);
    press(0, 25);
    tick(12);
    chk("mode_long", working_mode, 0);
    evt_ready = 1'b0;
    press(1, 10);
    tick(12);
    press(2, 10);
    tick(12);
    chk("bp_valid", evt_valid, 1);
    chk("bp_key", evt_key, 1);
    chk("bp_type", evt_type, 2'b01);
    chk("bp_ovf_set", evt_overflow, 1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    tick(1);
    chk("bp_ovf_clr", evt_overflow, 0);
    chk("bp_still_held", evt_key, 1);
    expect_evt(1, 2'b01, 0);
    evt_ready = 1'b1;
    tick(3);
    chk("bp_drained", evt_valid, 0);
    expect_evt(0, 2'b01, 0);
    press(0, 10);
    tick(12);
    chk("pre_rst_mode", working_mode, 1);
    key_n[1] = 1'b0;
    tick(10);
    chk("pre_rst_level", key_level[1], 1);
    rst = 1'b1;
    tick(2);
    chk("mid_rst_level", key_level, 0);
    chk("mid_rst_valid", evt_valid, 0);
    chk("mid_rst_key", evt_key, 0);
    chk("mid_rst_type", evt_type, 0);
    chk("mid_rst_ovf", evt_overflow, 0);
    chk("mid_rst_mode", working_mode, 0);
    rst = 1'b0;
    tick(4);
    chk("post_rst_not_yet", key_level[1], 0);
    tick(4);
    chk("post_rst_redebounced", key_level[1], 1);
    expect_evt(1, 2'b01, 0);
    key_n[1] = 1'b1;
    tick(12);
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
